// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared-multiplier front-end.
package mul_share_pkg;

    localparam int OPW = 8;   // operand width
    localparam int PRW = 16;  // product width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Index that follows idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_shift_add_core.sv
// 8x8 sequential shift-add multiplier: one multiplier bit per cycle,
// finishing early once the remaining multiplier bits are all zero.
module shift_add_core
    import mul_share_pkg::*;
(
    input  logic           clk,
    input  logic           load,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           done,
    output logic [PRW-1:0] product
);

    logic [PRW-1:0] mcand_q;
    logic [OPW-1:0] mplier_q;
    logic [PRW-1:0] acc_q;

    // Load clears the accumulator; otherwise consume one multiplier bit.
    always_ff @(posedge clk) begin
        if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{(PRW-OPW){1'b0}}, a};
            mplier_q <= b;
        end else if (mplier_q != '0) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign done    = (mplier_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin front-end that time-shares one shift-add multiplier core
// among N_REQ requesters; one multiplication in flight at a time.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [OPW*N_REQ-1:0] req_a,
    input  logic [OPW*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [PRW-1:0]       resp_data,
    output logic                 busy
);

    state_t         state_q, state_d;
    logic [IDX_W-1:0] rr_ptr, owner, pick;
    logic [OPW-1:0] a_q, b_q;
    logic [PRW-1:0] prod_q;
    logic [N_REQ-1:0] grant;
    logic           found;
    int             idx;

    logic           core_load, core_done;
    logic [PRW-1:0] core_product;

    shift_add_core u_core (
        .clk     (clk),
        .load    (core_load),
        .a       (a_q),
        .b       (b_q),
        .done    (core_done),
        .product (core_product)
    );

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                pick       = IDX_W'(idx);
                found      = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;

    // Next-state and core control; the core done flag is only trusted in RUN.
    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        case (state_q)
            IDLE: if (|req_ready) state_d = LOAD;
            LOAD: begin
                core_load = 1'b1;
                state_d   = RUN;
            end
            RUN:  if (core_done) state_d = RESP;
            RESP: if (resp_ready[owner]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand/owner capture, product capture and pointer rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req_ready) begin
                owner <= pick;
                a_q   <= req_a[pick*OPW +: OPW];
                b_q   <= req_b[pick*OPW +: OPW];
            end
            if (state_q == RUN && core_done)
                prod_q <= core_product;
            if (state_q == RESP && resp_ready[owner])
                rr_ptr <= IDX_W'(rr_next(int'(owner), N_REQ));
        end
    end

    // Result is presented only to the owner of the in-flight request.
    always_comb begin
        resp_valid = '0;
        if (state_q == RESP)
            resp_valid[owner] = 1'b1;
    end

    assign resp_data = prod_q;
    assign busy      = (state_q != IDLE);

endmodule
